shader_sequencer: RTL

//   Frame-level scheduler for the shader pipeline. Selects which of NUM_SHADERS

---
 rtl/shader_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/shader_sequencer.sv
// Frame-level shader scheduler: dwell on each shader, blank across the switch, restart the new one.
// Optional build macro SHADER_SEQ_LFSR_EN selects a pseudo-random, never-repeating next shader.
module shader_sequencer #(
  parameter int unsigned NUM_SHADERS  = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned DWELL_FRAMES = 600,
  parameter int unsigned BLANK_FRAMES = 8,
  parameter int unsigned CNT_W        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_end,
  input  logic             disp_active,
  input  logic             next_req,
  input  logic             pause_toggle,
  input  logic [23:0]      rgb_in,
  output logic [SEL_W-1:0] shader_sel,
  output logic             shader_rst,
  output logic             blank,
  output logic             paused,
  output logic [23:0]      rgb_out
);

  typedef enum logic {RUN, FADE} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_SHADERS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] dwell, blank_cnt;
  logic             req_pend;
  logic             start_fade, end_fade;
  logic [SEL_W-1:0] sel_inc, sel_next_idx;

  assign sel_inc = (shader_sel == SEL_LAST) ? '0 : shader_sel + 1'b1;

`ifdef SHADER_SEQ_LFSR_EN
  logic [7:0]       lfsr;
  logic [SEL_W-1:0] lfsr_pick;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lfsr_pick    = SEL_W'(lfsr % 8'(NUM_SHADERS));
  assign sel_next_idx = (lfsr_pick == shader_sel) ? sel_inc : lfsr_pick;
`else
  assign sel_next_idx = sel_inc;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_fade = 1'b0;
    end_fade   = 1'b0;
    case (state)
      RUN: begin
        if (frame_end && (req_pend || next_req || (!paused && dwell == DWELL_LAST))) begin
          start_fade = 1'b1;
          state_next = FADE;
        end
      end
      FADE: begin
        if (frame_end && blank_cnt == BLANK_LAST) begin
          end_fade   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    blank = (state == FADE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shader_sel <= '0;
      dwell      <= '0;
      blank_cnt  <= '0;
      req_pend   <= 1'b0;
      paused     <= 1'b0;
      shader_rst <= 1'b0;
      rgb_out    <= '0;
    end else begin
      paused     <= paused ^ pause_toggle;
      shader_rst <= end_fade;
      rgb_out    <= (blank || !disp_active) ? '0 : rgb_in;
      case (state)
        RUN: begin
          if (start_fade) begin
            dwell     <= '0;
            blank_cnt <= '0;
            req_pend  <= 1'b0;
          end else begin
            if (next_req) req_pend <= 1'b1;
            // dwell cannot pass DWELL_LAST: reaching it unpaused starts the fade instead
            if (frame_end && !paused) dwell <= dwell + 1'b1;
          end
        end
        FADE: begin
          if (end_fade)       shader_sel <= sel_next_idx;
          else if (frame_end) blank_cnt  <= blank_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
